// File: rtl/regex_memory_arbiter_pkg.sv
// Shared defaults for the instruction-memory arbiter that sits between the
// regex CPUs and the single synchronous instruction memory.
package regex_memory_arbiter_pkg;

  localparam int N_CPU_DEFAULT             = 4;
  localparam int MEMORY_WIDTH_DEFAULT      = 16;
  localparam int MEMORY_ADDR_WIDTH_DEFAULT = 11;

endpackage

// File: rtl/regex_memory_arbiter_round_robin_picker.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping from N-1 back to 0, wins a one-hot grant.
module round_robin_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      // N is a power of two, so the IW-bit add wraps modulo N for free.
      idx = ptr + IW'(k);
      if (!any_grant && req[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/regex_memory_arbiter.sv
// Round-robin arbiter letting N_CPU regex CPUs share one synchronous
// instruction memory; read data is steered back to per-CPU holding registers.
module regex_memory_arbiter
  import regex_memory_arbiter_pkg::*;
#(
  parameter int N_CPU             = N_CPU_DEFAULT,
  parameter int MEMORY_WIDTH      = MEMORY_WIDTH_DEFAULT,
  parameter int MEMORY_ADDR_WIDTH = MEMORY_ADDR_WIDTH_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_CPU-1:0]                    cpu_memory_valid,
  input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]  cpu_memory_addr,
  output logic [N_CPU-1:0]                    cpu_memory_ready,
  output logic [N_CPU*MEMORY_WIDTH-1:0]       cpu_memory_data,
  input  logic                                mem_busy,
  output logic                                mem_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]        mem_addr,
  input  logic [MEMORY_WIDTH-1:0]             mem_data
);

  localparam int IDW = $clog2(N_CPU);

  logic [N_CPU-1:0]                   hold_q, hold_d;
  logic [IDW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic                               resp_valid_q, resp_valid_d;
  logic [IDW-1:0]                     resp_id_q, resp_id_d;
  logic [N_CPU-1:0][MEMORY_WIDTH-1:0] data_q;

  logic [N_CPU-1:0] eligible;
  logic [N_CPU-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_grant;

  // Reset gates eligibility so ready/mem_en drop the instant rst goes low.
  // The hold mask hides the CPU served last cycle while its valid falls.
  assign eligible = (rst && !mem_busy) ? (cpu_memory_valid & ~hold_q) : '0;

  round_robin_picker #(
    .N (N_CPU)
  ) u_picker (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign cpu_memory_ready = grant;
  assign mem_en           = any_grant;
  assign cpu_memory_data  = data_q;

  // One-hot AND-OR mux of the granted CPU's address; zero when idle.
  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (grant[i]) begin
        mem_addr = mem_addr | cpu_memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    hold_d       = grant;
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = any_grant;
    resp_id_d    = grant_idx;
    if (any_grant) begin
      rr_ptr_d = grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q       <= '0;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      hold_q       <= hold_d;
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // NOTE: the per-CPU data registers are real flops read directly by the CPUs,
  // so they are reset to a known zero rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (resp_valid_q) begin
      data_q[resp_id_q] <= mem_data;
    end
  end

endmodule

// File: doc/regex_memory_arbiter.md
REGEX_MEMORY_ARBITER -- requirements
Module: regex_memory_arbiter

Interface
REQ-001 Parameter N_CPU, default 4: number of regex_cpu memory ports sharing one instruction memory; power of two, 2..16.
REQ-002 Parameter MEMORY_WIDTH, default 16: instruction word width.
REQ-003 Parameter MEMORY_ADDR_WIDTH, default 11: instruction address width.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port cpu_memory_valid, input, N_CPU: per-CPU fetch request.
REQ-007 Port cpu_memory_addr, input, N_CPU*MEMORY_ADDR_WIDTH: per-CPU fetch address; CPU i occupies slice i.
REQ-008 Port cpu_memory_ready, output, N_CPU: one-hot grant pulse to the served CPU.
REQ-009 Port cpu_memory_data, output, N_CPU*MEMORY_WIDTH: per-CPU returned instruction word.
REQ-010 Port mem_busy, input, 1: memory owned by loader; no grants while high.
REQ-011 Port mem_en, output, 1: synchronous-memory read enable.
REQ-012 Port mem_addr, output, MEMORY_ADDR_WIDTH: memory read address.
REQ-013 Port mem_data, input, MEMORY_WIDTH: memory read data, valid exactly 1 cycle after mem_en.

Function
REQ-014 At most one grant per cycle; cpu_memory_ready SHALL be zero or one-hot.
REQ-015 Grant cycle: cpu_memory_ready[i]=1, mem_en=1, mem_addr=cpu_memory_addr slice i, all combinational from the current-cycle arbitration result.
REQ-016 Eligible set = cpu_memory_valid AND NOT hold_mask, empty when mem_busy=1.
REQ-017 hold_mask SHALL contain only the CPU granted in the previous cycle, absorbing its registered valid drop; cleared the cycle after.
REQ-018 Arbitration round-robin: search starts at rr_ptr, wraps from N_CPU-1 to 0; after a grant to i, rr_ptr=(i+1) mod N_CPU.
REQ-019 No grant: rr_ptr unchanged, mem_en=0, cpu_memory_ready=0.
REQ-020 Response pipeline register (resp_valid, resp_id) SHALL record each grant; next cycle mem_data is written into data register resp_id.
REQ-021 cpu_memory_data slice i SHALL be registered, updated only by its own response, and held stable until the next response to CPU i.
REQ-022 Latency: request to ready is 0 cycles when eligible and first in round-robin order; ready to cpu_memory_data valid is 2 clock edges (data visible the cycle after the ready-following cycle edge); worst-case wait is N_CPU-1 grant slots.
REQ-023 Throughput: one grant every cycle when two or more CPUs request; a lone requester is served at most every other cycle (REQ-017).
REQ-024 mem_busy rising during an outstanding response SHALL still complete that response; only new grants are blocked.
REQ-025 A CPU dropping valid before being granted SHALL simply lose eligibility; no error state.

Reset
REQ-026 On rst low, immediately: cpu_memory_ready=0, mem_en=0, mem_addr=0, rr_ptr=0, hold_mask=0, resp_valid=0, all cpu_memory_data=0.
REQ-027 Reset mid-response SHALL discard the in-flight word; no data register updated.
REQ-028 First grant possible in the first cycle with rst high.

Structure
REQ-029 Shared package (alongside instruction_package) SHALL hold MEMORY_WIDTH/MEMORY_ADDR_WIDTH defaults and the N_CPU default.
REQ-030 One sub-module, round_robin_picker (request vector, pointer -> one-hot grant, grant index, any_grant), combinational.
REQ-031 Memory model remains outside the block.

Verification
REQ-032 Single CPU 2 requests addr 0x06E, mem returns 0x1234 -> ready[2] pulse same cycle, mem_addr=0x06E, cpu_memory_data slice 2=0x1234 after the response edge, other slices unchanged.
REQ-033 All 4 CPUs request simultaneously from reset -> grants 0,1,2,3 on consecutive cycles, each receives its own address's word.
REQ-034 CPU 1 holds valid continuously for 6 cycles with no others -> ready[1] only on alternate cycles, never back-to-back.
REQ-035 mem_busy=1 with CPUs 0 and 3 requesting for 5 cycles -> no ready, mem_en=0; after release, CPU 0 granted first, CPU 3 next.
REQ-036 rst asserted the cycle after a grant to CPU 2 -> all outputs zero immediately, slice 2 stays 0, rr_ptr restarts at 0.
REQ-037 Randomized 4-CPU split/fetch traffic, 10k cycles -> every request served within 4 grant slots, scoreboard data matches memory, ready always one-hot or zero.
